// File: rtl/mux31_rr_scheduler_pkg.sv
// Shared types, sizing constants and pointer helper for the 31-way
// round-robin mux scheduler.
package mux31_sched_pkg;

    localparam int NREQ   = 31;
    localparam int SEL_W  = 5;
    localparam int DATA_W = 2;

    // Unmapped select code: the mux drives zero while parked here.
    localparam logic [SEL_W-1:0] PARK_SEL = 5'd31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        PRESENT = 2'd2
    } state_e;

    // Pointer advances past the served index; 30 wraps to 0 rather than
    // rolling into the parked code 31.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
        if (idx >= SEL_W'(NREQ - 1)) begin
            return '0;
        end
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux31_rr_scheduler_if.sv
// Downstream valid/ready channel carrying the captured mux value and its
// source index.
interface mux31_rr_scheduler_if;
    import mux31_sched_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_src;

    modport master (
        output out_valid,
        output out_data,
        output out_src,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_src,
        output out_ready
    );

endinterface

// File: rtl/mux31_rr_scheduler_pick.sv
// Rotate-priority find-first: first set request at or after ptr, wrapping
// from index 30 back to 0.
module rr_pick
    import mux31_sched_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (pos >= (SEL_W + 1)'(NREQ)) begin
                pos = pos - (SEL_W + 1)'(NREQ);
            end
            if (!found && req[pos[SEL_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux31_rr_scheduler.sv
// Round-robin scheduler owning the 31-input mux select: grants one requester,
// waits one settle cycle, then presents the mux output downstream.
module mux31_rr_scheduler
    import mux31_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    output logic [SEL_W-1:0]     sel,
    input  logic [DATA_W-1:0]    mux_out,
    mux31_rr_scheduler_if.master dn
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_src_q, out_src_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic [SEL_W-1:0]  pick_ptr;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              accept;

    // On the accepting cycle arbitration must already see the advanced pointer.
    assign pick_ptr = (state_q == PRESENT) ? next_ptr(out_src_q) : ptr_q;
    assign accept   = out_valid_q && dn.out_ready;

    rr_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;

        case (state_q)
            IDLE: begin
                sel_d = PARK_SEL;
                gnt_d = '0;
                if (pick_found) begin
                    sel_d   = pick_idx;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                out_data_d  = mux_out;
                out_src_d   = sel_q;
                out_valid_d = 1'b1;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (accept) begin
                    ptr_d       = next_ptr(out_src_q);
                    out_valid_d = 1'b0;
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        state_d = SELECT;
                    end else begin
                        sel_d   = PARK_SEL;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                sel_d       = PARK_SEL;
                gnt_d       = '0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= PARK_SEL;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign sel          = sel_q;
    assign gnt          = gnt_q;
    assign dn.out_valid = out_valid_q;
    assign dn.out_data  = out_data_q;
    assign dn.out_src   = out_src_q;

endmodule
